// File: rtl/display_frame_scheduler.sv
// Display frame scheduler: latches the committed frame base at each accepted
// frame start, then walks the active lines issuing one DMA read per line with
// a bounded number of reads in flight. Runs in the display pixel clock domain.
module display_frame_scheduler #(
    parameter string DISPLAY_MODE    = "640x480_60Hz",
    parameter int    LINE_STRIDE     = 8192,
    parameter int    MAX_OUTSTANDING = 2
) (
    input  logic        lvds_slowclk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [31:0] next_base,
    input  logic        commit,
    input  logic        vsync_fall,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [31:0] cmd_addr,
    output logic [15:0] cmd_bytes,
    input  logic        cmd_done,
    output logic        flip_done,
    output logic [31:0] active_base,
    output logic        busy,
    output logic [15:0] debug_late_count
);

    // Geometry derived from the selected display mode (2 pixels per 64-bit word).
    localparam int LINE_WORDS = (DISPLAY_MODE == "1920x1080_60Hz") ? 960 :
                                (DISPLAY_MODE == "1280x720_60Hz")  ? 640 : 320;
    localparam int LINES      = (DISPLAY_MODE == "1920x1080_60Hz") ? 1080 :
                                (DISPLAY_MODE == "1280x720_60Hz")  ? 720  : 480;

    localparam logic [15:0] LINE_BYTES = 16'(LINE_WORDS * 8);
    localparam logic [31:0] STRIDE     = 32'(LINE_STRIDE);
    localparam logic [10:0] LAST_LINE  = 11'(LINES - 1);
    localparam logic [2:0]  MAX_OUT    = 3'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } state_t;

    state_t      state_q, state_d;
    logic        pending_q, pending_d;
    logic [31:0] pending_base_q, pending_base_d;
    logic [31:0] active_base_q, active_base_d;
    logic [31:0] addr_q, addr_d;
    logic [10:0] line_q, line_d;
    logic [2:0]  outst_q, outst_d;
    logic        flip_q, flip_d;
    logic        busy_q, busy_d;
    logic [15:0] late_q, late_d;

    logic        handshake;
    logic        frame_start;

    // A command is offered only while fetching lines and below the in-flight limit;
    // since the in-flight count cannot rise without a handshake, valid holds until accepted.
    assign cmd_valid   = (state_q == ISSUE) && (outst_q < MAX_OUT);
    assign handshake   = cmd_valid && cmd_ready;
    assign frame_start = vsync_fall && enable;

    assign cmd_addr         = addr_q;
    assign cmd_bytes        = LINE_BYTES;
    assign flip_done        = flip_q;
    assign active_base      = active_base_q;
    assign busy             = busy_q;
    assign debug_late_count = late_q;

    // Next-state logic: frame sequencing, address accumulation, commit capture and counters.
    always_comb begin
        state_d        = state_q;
        pending_d      = pending_q;
        pending_base_d = pending_base_q;
        active_base_d  = active_base_q;
        addr_d         = addr_q;
        line_d         = line_q;
        outst_d        = outst_q;
        flip_d         = 1'b0;
        busy_d         = busy_q;
        late_d         = late_q;

        case (state_q)
            IDLE: begin
                if (frame_start) begin
                    state_d = ISSUE;
                    line_d  = '0;
                    busy_d  = 1'b1;
                    if (pending_q) begin
                        active_base_d = pending_base_q;
                        addr_d        = pending_base_q;
                        pending_d     = 1'b0;
                        flip_d        = 1'b1;
                    end else begin
                        addr_d = active_base_q;
                    end
                end
            end
            ISSUE: begin
                if (handshake) begin
                    line_d = line_q + 11'd1;
                    addr_d = addr_q + STRIDE;
                    if (line_q == LAST_LINE) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (outst_q == 3'd0) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A frame start that arrives mid-frame is only counted, never honoured.
        if (frame_start && busy_q && (late_q != 16'hFFFF)) begin
            late_d = late_q + 16'd1;
        end

        // Handshake and completion in the same cycle cancel; stray completions are dropped.
        if (handshake && !cmd_done) begin
            outst_d = outst_q + 3'd1;
        end else if (!handshake && cmd_done && (outst_q != 3'd0)) begin
            outst_d = outst_q - 3'd1;
        end

        // Evaluated after the frame-start flip so a commit in the same cycle stays
        // pending for the following frame.
        if (commit) begin
            pending_d      = 1'b1;
            pending_base_d = next_base & 32'hFFFF_FFF8;
        end
    end

    // State and datapath registers.
    always_ff @(posedge lvds_slowclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            pending_q      <= 1'b0;
            pending_base_q <= '0;
            active_base_q  <= '0;
            addr_q         <= '0;
            line_q         <= '0;
            outst_q        <= '0;
            flip_q         <= 1'b0;
            busy_q         <= 1'b0;
            late_q         <= '0;
        end else begin
            state_q        <= state_d;
            pending_q      <= pending_d;
            pending_base_q <= pending_base_d;
            active_base_q  <= active_base_d;
            addr_q         <= addr_d;
            line_q         <= line_d;
            outst_q        <= outst_d;
            flip_q         <= flip_d;
            busy_q         <= busy_d;
            late_q         <= late_d;
        end
    end

endmodule

// File: doc/display_frame_scheduler.md
Name: display_frame_scheduler

Overview:
Sequences the display read DMA for the LVDS display path. At every frame boundary it latches the committed frame-buffer base address. It then issues one DMA read command per active line, at base + line*LINE_STRIDE, with a bounded number of commands outstanding. It reports buffer flips and late frames to software. It sits between the register bank and the DMA command channel, and runs in the display pixel clock domain.

Parameters:
DISPLAY_MODE, "640x480_60Hz", selects the geometry; legal values are "640x480_60Hz", "1280x720_60Hz", "1920x1080_60Hz".
LINE_WORDS, derived from DISPLAY_MODE as 320/640/960, gives the 64-bit words per line (2 pixels per word).
LINES, derived from DISPLAY_MODE as 480/720/1080, gives the active lines per frame.
LINE_STRIDE, 8192, is the byte distance between line starts; it must be ≥ LINE_WORDS*8 and a multiple of 8.
MAX_OUTSTANDING, 2, is the number of issued but not completed commands allowed; the range is 1..7.

Ports:
lvds_slowclk  in  1  display pixel clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  level; when 0, no new frame is started
next_base  in  32  software-provided frame base; 8-byte aligned (bits [2:0] are ignored and forced to 0)
commit  in  1  single-cycle pulse; arms next_base for the next frame start
vsync_fall  in  1  single-cycle frame-start pulse from the display timing
cmd_valid  out  1  DMA command valid
cmd_ready  in  1  DMA command accept
cmd_addr  out  32  line start byte address
cmd_bytes  out  16  line length in bytes (LINE_WORDS*8)
cmd_done  in  1  single-cycle pulse, one per completed command
flip_done  out  1  single-cycle pulse when a committed base becomes active
active_base  out  32  base of the frame currently being fetched
busy  out  1  high from frame start until the last cmd_done
debug_late_count  out  16  count of vsync_fall pulses that arrive while busy; saturates

Behaviour:
Reset values (asynchronous, all outputs): cmd_valid=0, cmd_addr=0, cmd_bytes=LINE_WORDS*8 (constant), flip_done=0, active_base=0, busy=0, debug_late_count=0. The internal pending flag, line counter and outstanding counter also reset to 0, and the FSM resets to IDLE.

Commit handling:
- commit captures next_base into pending_base and sets pending=1.
- A later commit before the next frame start overwrites pending_base; the last write wins.

FSM states:
- IDLE: on vsync_fall && enable, go to ISSUE. Same cycle actions: if pending, active_base<=pending_base, pending<=0, and flip_done pulses the next cycle. Also line<=0 and busy<=1.
- ISSUE: cmd_valid=1 whenever outstanding < MAX_OUTSTANDING. cmd_addr = active_base + line*LINE_STRIDE, computed with an accumulator (no multiplier) and truncated to 32 bits, so wrap-around is allowed.
  - cmd_valid, once asserted, holds with a stable cmd_addr until cmd_ready.
  - On cmd_valid&&cmd_ready: line++ and outstanding++.
  - After the handshake for line LINES-1, go to DRAIN.
- DRAIN: wait until outstanding==0, then go to IDLE with busy<=0 in the same cycle.

Outstanding counter:
- +1 on a handshake, -1 on cmd_done. Simultaneous handshake and cmd_done leave it unchanged.
- A cmd_done while outstanding==0 is ignored (no underflow).

Frame-start corner cases:
- vsync_fall while busy: debug_late_count++ (saturating at 16'hFFFF). The current frame continues and no new frame starts; the next accepted start is the next vsync_fall seen in IDLE.
- vsync_fall while enable=0: ignored and not counted as late.
- Deasserting enable mid-frame does not abort; the frame completes normally.
- Simultaneous commit and vsync_fall in IDLE: the old pending value, if any, is flipped. The new next_base stays pending for the following frame.

Latency:
- cmd_valid for line 0 first asserts 1 cycle after the accepting vsync_fall.
- Back-to-back commands are possible with 1 handshake per cycle while below the outstanding limit.

Test Plan:
- Reset, then commit next_base=0x1000_0000, then vsync_fall with enable=1 and cmd_ready held 1, cmd_done returned 2 cycles after each accept (640x480):
  - flip_done pulses once and active_base=0x1000_0000.
  - Exactly 480 commands issue; addresses run 0x1000_0000, 0x1000_2000, …, 0x103B_E000 with cmd_bytes=2560.
  - busy falls after the 480th cmd_done.
- cmd_ready held 1 and cmd_done withheld:
  - Exactly MAX_OUTSTANDING=2 commands issue, then cmd_valid drops.
  - One cmd_done yields exactly one more command.
- cmd_ready toggled randomly: cmd_addr stays stable while cmd_valid=1 and cmd_ready=0, and no line is skipped or duplicated.
- Second vsync_fall mid-frame: debug_late_count goes to 1, the line sequence is uninterrupted, and the next vsync_fall in IDLE starts a new frame.
- Two commits (A, then B) before vsync_fall: active_base=B and flip_done pulses once. A following frame with no commit keeps active_base=B with no flip_done.
- rst_n asserted mid-ISSUE: all outputs return to reset values immediately, and a subsequent vsync_fall with no commit fetches from base 0.
